inv_pipe: RTL and testbench

INV_PIPE -- requirements
Module: inv_pipe

---
 rtl/inv_pipe.sv | 117 +++++++++++
 tb/tb_inv_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_pipe.sv
// Elastic pipeline that passes, inverts, masks or alternately inverts each
// accepted word, plus a count of delivered words.
module inv_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic [15:0]      word_cnt
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_MASK = 2'b10;
  localparam logic [1:0] MODE_ALT  = 2'b11;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [1:0]        mode_q, mode_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic              phase_q, phase_d;
  logic [15:0]       word_cnt_q, word_cnt_d;

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              accept;
  logic              deliver;
  logic [WIDTH-1:0]  xform;

  // A stage advances when the output drains or any later stage has a hole,
  // written without a ripple chain through adv itself.
  always_comb begin
    adv = '0;
    for (int i = 0; i < STAGES; i++) begin
      adv[i] = out_ready;
      for (int j = i + 1; j < STAGES; j++) begin
        if (!valid_q[j]) adv[i] = 1'b1;
      end
    end
  end

  assign load      = ~valid_q | adv;
  assign in_ready  = rst_n & load[0];
  assign accept    = in_valid & in_ready;
  assign deliver   = valid_q[STAGES-1] & out_ready;
  assign out_valid = valid_q[STAGES-1];
  assign Y         = data_q[STAGES-1];
  assign busy      = |valid_q;
  assign word_cnt  = word_cnt_q;

  always_comb begin
    xform = A;
    case (mode_q)
      MODE_PASS: xform = A;
      MODE_INV:  xform = ~A;
      MODE_MASK: xform = A ^ mask_q;
      MODE_ALT:  xform = phase_q ? ~A : A;
      default:   xform = A;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load[0]) valid_d[0] = in_valid;
    if (accept)  data_d[0]  = xform;
    for (int i = 1; i < STAGES; i++) begin
      if (load[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) data_d[i] = data_q[i-1];
      end
    end

    mode_d  = mode_q;
    mask_d  = mask_q;
    phase_d = phase_q;
    if (accept && (mode_q == MODE_ALT)) phase_d = ~phase_q;
    // A config write restarts the alternate sequence even on an accept cycle.
    if (cfg_we) begin
      mode_d  = cfg_mode;
      mask_d  = cfg_mask;
      phase_d = 1'b0;
    end

    word_cnt_d = word_cnt_q + {15'd0, deliver};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      mode_q     <= MODE_PASS;
      mask_q     <= '0;
      phase_q    <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      phase_q    <= phase_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_inv_pipe.sv
// Directed and randomized checks of inv_pipe (WIDTH=8, STAGES=2) against a
// queue-based reference of the transform and the handshake.
module tb_inv_pipe;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [1:0]   cfg_mode;
  logic [W-1:0] cfg_mask;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         busy;
  logic [15:0]  word_cnt;

  inv_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .cfg_mask(cfg_mask), .in_valid(in_valid), .in_ready(in_ready), .A(a),
    .out_valid(out_valid), .out_ready(out_ready), .Y(y), .busy(busy),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;
  int n_deliv  = 0;

  logic [1:0]   m_mode  = 2'b00;
  logic [W-1:0] m_mask  = '0;
  logic         m_phase = 1'b0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] mask;
    logic [W-1:0] din;
    logic [W-1:0] dout;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_xf(input logic [1:0] md, input logic [W-1:0] mk,
                                             input logic ph, input logic [W-1:0] d);
    case (md)
      2'b00:   return d;
      2'b01:   return ~d;
      2'b10:   return d ^ mk;
      default: return ph ? ~d : d;
    endcase
  endfunction

  // Drives one cycle (entered and left 1ns after a rising edge) and keeps the
  // reference queue in step with the handshakes that happen at the next edge.
  task automatic do_cycle(input logic we, input logic [1:0] md, input logic [W-1:0] mk,
                          input logic iv, input logic [W-1:0] d, input logic ordy);
    cfg_we = we; cfg_mode = md; cfg_mask = mk;
    in_valid = iv; a = d; out_ready = ordy;
    #1;
    check("busy", busy, exp_q.size() != 0);
    check("in_ready", in_ready, !(exp_q.size() == S && !ordy));
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) check("unexpected_word", 1, 0);
      else check("y_order", y, exp_q.pop_front());
      got_q.push_back(y);
      n_deliv++;
    end
    if (iv && in_ready) begin
      exp_q.push_back(model_xf(m_mode, m_mask, m_phase, d));
      n_acc++;
      if (m_mode == 2'b11) m_phase = ~m_phase;
    end
    if (we) begin
      m_mode = md; m_mask = mk; m_phase = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, 2'b00, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic cfg(input logic [1:0] md, input logic [W-1:0] mk);
    do_cycle(1'b1, md, mk, 1'b0, '0, 1'b1);
  endtask

  task automatic send(input logic [W-1:0] d);
    do_cycle(1'b0, 2'b00, '0, 1'b1, d, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle();
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    vec_t vecs [8];
    logic [W-1:0] alt_exp [4];
    int acc0, del0;

    vecs[0] = '{2'b00, 8'h00, 8'h3C, 8'h3C};
    vecs[1] = '{2'b01, 8'h00, 8'h3C, 8'hC3};
    vecs[2] = '{2'b10, 8'h0F, 8'h3C, 8'h33};
    vecs[3] = '{2'b10, 8'hF0, 8'hA5, 8'h55};
    vecs[4] = '{2'b11, 8'h00, 8'h81, 8'h81};
    vecs[5] = '{2'b01, 8'h00, 8'h00, 8'hFF};
    vecs[6] = '{2'b00, 8'hFF, 8'hFF, 8'hFF};
    vecs[7] = '{2'b10, 8'hFF, 8'h00, 8'hFF};
    alt_exp[0] = 8'h00; alt_exp[1] = 8'hFF; alt_exp[2] = 8'h00; alt_exp[3] = 8'hFF;

    // Reset state, with upstream already offering a word.
    rst_n = 1'b0; cfg_we = 1'b0; cfg_mode = 2'b01; cfg_mask = 8'hFF;
    in_valid = 1'b1; a = 8'h99; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_y", y, 0);
    check("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: accepted at cycle 0, visible at cycle 2.
    cfg(2'b01, 8'h00);
    send(8'h5A);
    check("lat_c1_out_valid", out_valid, 0);
    idle();
    check("lat_c2_out_valid", out_valid, 1);
    check("lat_c2_y", y, 8'hA5);
    idle();
    check("lat_word_cnt", word_cnt, 1);

    for (int v = 0; v < 8; v++) begin
      cfg(vecs[v].mode, vecs[v].mask);
      got_q.delete();
      send(vecs[v].din);
      drain();
      check("vec_count", got_q.size(), 1);
      if (got_q.size() > 0) check($sformatf("vec%0d_y", v), got_q[0], vecs[v].dout);
    end

    // Config write on the accept cycle applies from the following word.
    cfg(2'b10, 8'h0F);
    do_cycle(1'b1, 2'b00, 8'h00, 1'b1, 8'h3C, 1'b1);
    send(8'h3C);
    check("cfg_same_cycle_y", y, 8'h33);
    idle();
    check("cfg_next_word_y", y, 8'h3C);
    drain();

    // Alternate-invert sequence and its restart on a config write.
    cfg(2'b11, 8'h00);
    got_q.delete();
    for (int k = 0; k < 4; k++) send(8'h00);
    drain();
    check("alt_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) check($sformatf("alt%0d", k), got_q[k], alt_exp[k]);
    got_q.delete();
    send(8'h00);
    cfg(2'b11, 8'h00);
    send(8'h00);
    drain();
    check("alt_restart_count", got_q.size(), 2);
    if (got_q.size() > 1) check("alt_restart_y", got_q[1], 8'h00);

    // Back-pressure: exactly S words enter, then release in order.
    cfg(2'b00, 8'h00);
    acc0 = n_acc;
    for (int k = 0; k < 5; k++) do_cycle(1'b0, 2'b00, '0, 1'b1, 8'h10 + 8'(k), 1'b0);
    check("bp_accepts", n_acc - acc0, S);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_y_held", y, 8'h10);
    got_q.delete();
    idle();
    idle();
    check("bp_release_count", got_q.size(), 2);
    if (got_q.size() > 1) begin
      check("bp_first", got_q[0], 8'h10);
      check("bp_second", got_q[1], 8'h11);
    end

    // Full pipe with simultaneous accept and deliver keeps one word per cycle.
    do_cycle(1'b0, 2'b00, '0, 1'b1, 8'h20, 1'b0);
    do_cycle(1'b0, 2'b00, '0, 1'b1, 8'h21, 1'b0);
    acc0 = n_acc;
    del0 = n_deliv;
    for (int k = 0; k < 6; k++) do_cycle(1'b0, 2'b00, '0, 1'b1, 8'h30 + 8'(k), 1'b1);
    check("full_tput_acc", n_acc - acc0, 6);
    check("full_tput_del", n_deliv - del0, 6);
    drain();

    for (int k = 0; k < 10000; k++) begin
      do_cycle($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)), 8'($urandom),
               1'($urandom), 8'($urandom), 1'($urandom));
    end
    drain();
    check("rand_no_loss", n_acc, n_deliv);
    check("rand_word_cnt", word_cnt, n_deliv % 65536);

    // Asynchronous reset with a full pipe.
    cfg(2'b01, 8'h00);
    do_cycle(1'b0, 2'b00, '0, 1'b1, 8'h11, 1'b0);
    do_cycle(1'b0, 2'b00, '0, 1'b1, 8'h22, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_word_cnt", word_cnt, 0);
    check("arst_y", y, 0);
    exp_q.delete();
    m_mode = 2'b00; m_mask = '0; m_phase = 1'b0;
    n_deliv = 0; n_acc = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    send(8'h77);
    drain();
    check("post_rst_count", got_q.size(), 1);
    if (got_q.size() > 0) check("post_rst_y", got_q[0], 8'h77);
    check("post_rst_word_cnt", word_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
